axil_cmd_master: RTL and testbench

- AXI4-Lite master (initiator) that turns a simple command handshake into single AXI-Lite write or read transactions.
- It is the counterpart of the accelerator's AXI-Lite register slave. Benches and on-chip sequencers use it to program the control word `{last, run, matw}` at 0x000 and the control register at 0x010, and to read them back.
- One transaction is in flight at a time; the response is held until consumed.
- A watchdog flags a slave that never completes a transaction.

---
 rtl/axil_cmd_master.sv | 157 +++++++++++++++
 tb/tb_axil_cmd_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// axil_cmd_master
//   Accepts one command at a time and runs it as a single AXI4-Lite write or
//   read. The response is held on the rsp_* port until it is consumed.
//   A watchdog raises a sticky flag when the slave stalls for TIMEOUT cycles.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/ready/we/addr/wdata/strb
//                                 command handshake (we: 1 = write, 0 = read)
//   rsp_valid/ready/we/rdata/resp response handshake (rdata is 0 for writes)
//   busy                          high whenever a command is being processed
//   timeout                       sticky watchdog flag, cleared on next accept
//   M_AXI_*                       AXI4-Lite master interface
module axil_cmd_master #(
    parameter int TIMEOUT = 1024,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              busy,
    output logic              timeout,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    typedef enum logic [2:0] {S_IDLE, S_WA, S_WB, S_RA, S_RD, S_RSP} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    state_t            state;
    logic [ADDR_W-1:0] addr_r;
    logic [CW-1:0]     wd_cnt;

    assign cmd_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign M_AXI_AWADDR = addr_r;
    assign M_AXI_ARADDR = addr_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            addr_r        <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_we        <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            timeout       <= 1'b0;
            wd_cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // Masking keeps the address word-aligned.
                        addr_r      <= cmd_addr & ~ADDR_W'(3);
                        M_AXI_WDATA <= cmd_wdata;
                        M_AXI_WSTRB <= cmd_strb;
                        rsp_we      <= cmd_we;
                        timeout     <= 1'b0;
                        wd_cnt      <= '0;
                        if (cmd_we) begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= S_WA;
                        end else begin
                            M_AXI_ARVALID <= 1'b1;
                            state         <= S_RA;
                        end
                    end
                end
                S_WA: begin
                    // A cleared valid marks its channel as already done.
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) &&
                        (!M_AXI_WVALID  || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= S_WB;
                    end
                end
                S_WB: begin
                    if (M_AXI_BVALID) begin
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        M_AXI_BREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= S_RSP;
                    end
                end
                S_RA: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= S_RD;
                    end
                end
                S_RD: begin
                    if (M_AXI_RVALID) begin
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_resp     <= M_AXI_RRESP;
                        M_AXI_RREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Watchdog: counts bus-wait cycles and saturates at TIMEOUT.
            if ((state == S_WA || state == S_WB || state == S_RA || state == S_RD) &&
                wd_cnt != TO_MAX) begin
                wd_cnt <= wd_cnt + CW'(1);
                if (wd_cnt == TO_MAX - CW'(1)) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_we;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy, timeout;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axil_cmd_master #(.TIMEOUT(8), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .busy(busy), .timeout(timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic offer(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
    endtask

    // Zero-wait slave transaction: accept, one handshake cycle, response, consume.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        offer(v.we, v.addr, v.wdata, v.strb);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("acc_busy", busy, 1);
        chk("acc_timeout_clr", timeout, 0);
        if (v.we) begin
            chk("awvalid", awvalid, 1);
            chk("wvalid", wvalid, 1);
            chk("awaddr", awaddr, v.exp_addr);
            chk("wdata", wdata, v.wdata);
            chk("wstrb", wstrb, v.strb);
            chk("no_arvalid", arvalid, 0);
        end else begin
            chk("arvalid", arvalid, 1);
            chk("araddr", araddr, v.exp_addr);
            chk("no_awvalid", awvalid, 0);
        end
        @(negedge clk);
        if (v.we) begin
            chk("aw_dropped", awvalid, 0);
            chk("w_dropped", wvalid, 0);
            chk("bready", bready, 1);
            bvalid = 1'b1; bresp = v.resp;
        end else begin
            chk("ar_dropped", arvalid, 0);
            chk("rready", rready, 1);
            rvalid = 1'b1; rdata = v.rdata; rresp = v.resp;
        end
        @(negedge clk);
        bvalid = 1'b0; rvalid = 1'b0;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_we", rsp_we, v.we);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_resp", rsp_resp, v.resp);
        chk("bready_low", bready, 0);
        chk("rready_low", rready, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_consumed", rsp_valid, 0);
        chk("back_idle", cmd_ready, 1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0003, 4'hF, 2'b00, 32'h0, 32'h0000_0000, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 2'b00, 32'hA5A5_0001, 32'h0000_0010, 32'hA5A5_0001};
        vecs[2] = '{1'b1, 32'h0000_0012, 32'h1234_5678, 4'h5, 2'b10, 32'h0, 32'h0000_0010, 32'h0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 2'b11, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'h0, 2'b01, 32'h0, 32'hFFFF_FFFC, 32'h0};

        rst = 1'b1;
        cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
        rsp_ready = 0;
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0;

        #2;
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Split write: W accepted first, AW three cycles later.
        @(negedge clk);
        awready = 1'b0; wready = 1'b1;
        offer(1'b1, 32'h0000_0004, 32'h0000_0011, 4'h3);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("split_awvalid0", awvalid, 1);
        chk("split_wvalid0", wvalid, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("split_w_dropped", wvalid, 0);
            chk("split_aw_held", awvalid, 1);
            chk("split_awaddr", awaddr, 32'h4);
            chk("split_no_bready", bready, 0);
            if (i == 2) awready = 1'b1;
        end
        @(negedge clk);
        awready = 1'b0;
        chk("split_aw_dropped", awvalid, 0);
        chk("split_bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        chk("split_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("split_single_rsp", rsp_valid, 0);
            chk("split_idle", busy, 0);
            @(negedge clk);
        end

        // Read-back with delayed RVALID, then response backpressure.
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        offer(1'b0, 32'h0000_0013, 32'h0, 4'h0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rb_arvalid", arvalid, 1);
        chk("rb_araddr", araddr, 32'h10);
        @(negedge clk);
        chk("rb_rready1", rready, 1);
        @(negedge clk);
        chk("rb_rready2", rready, 1);
        chk("rb_no_rsp", rsp_valid, 0);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
        @(negedge clk);
        rvalid = 1'b0; rdata = 32'h0;
        chk("rb_rsp_valid", rsp_valid, 1);
        chk("rb_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("rb_resp", rsp_resp, 2'b10);
        offer(1'b1, 32'h0000_0010, 32'h0000_0001, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("bp_resp", rsp_resp, 2'b10);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_no_aw", awvalid, 0);
            if (i == 4) rsp_ready = 1'b1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_rsp_done", rsp_valid, 0);
        chk("bp_not_same_cycle", busy, 0);
        chk("bp_cmd_ready", cmd_ready, 1);
        chk("bp_no_aw_yet", awvalid, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_next_busy", busy, 1);
        chk("bp_next_aw", awvalid, 1);
        chk("bp_next_wdata", wdata, 32'h1);
        @(negedge clk);
        chk("bp_next_bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        chk("bp_next_rsp", rsp_valid, 1);
        chk("bp_next_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Watchdog: ARREADY withheld past TIMEOUT.
        arready = 1'b0;
        offer(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("wd_start", timeout, 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("wd_timeout", timeout, (k == 8));
            chk("wd_arvalid_held", arvalid, 1);
        end
        repeat (3) begin
            @(negedge clk);
            chk("wd_sticky", timeout, 1);
            chk("wd_arvalid_still", arvalid, 1);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("wd_ar_done", arvalid, 0);
        chk("wd_rready", rready, 1);
        rvalid = 1'b1; rdata = 32'h0000_0055; rresp = 2'b00;
        @(negedge clk);
        rvalid = 1'b0;
        chk("wd_rsp_valid", rsp_valid, 1);
        chk("wd_rdata", rsp_rdata, 32'h55);
        chk("wd_timeout_kept", timeout, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("wd_timeout_idle", timeout, 1);
        run_vec(vecs[0]);
        chk("wd_cleared", timeout, 0);

        // Async reset while stalled in WB with timeout raised.
        @(negedge clk);
        awready = 1'b1; wready = 1'b1;
        offer(1'b1, 32'h0000_0000, 32'h0000_0007, 4'hF);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("ar_pre_bready", bready, 1);
        chk("ar_pre_timeout", timeout, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_bready", bready, 0);
        chk("ar_awvalid", awvalid, 0);
        chk("ar_wvalid", wvalid, 0);
        chk("ar_arvalid", arvalid, 0);
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_timeout", timeout, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ar_cmd_ready", cmd_ready, 1);
        chk("ar_idle", busy, 0);
        chk("ar_bready_after", bready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
